// File: rtl/unidade_desvio_pkg.sv
// Shared types for the branch resolution stage: condition codes, FSM states
// and the bit positions of the Z/C/S/O flags.
package desvio_pkg;

  typedef enum logic [3:0] {
    COND_AL = 4'd0,
    COND_NV = 4'd1,
    COND_EQ = 4'd2,
    COND_NE = 4'd3,
    COND_CS = 4'd4,
    COND_CC = 4'd5,
    COND_MI = 4'd6,
    COND_PL = 4'd7,
    COND_VS = 4'd8,
    COND_VC = 4'd9,
    COND_LT = 4'd10,
    COND_GE = 4'd11,
    COND_LE = 4'd12,
    COND_GT = 4'd13,
    COND_LS = 4'd14,
    COND_HI = 4'd15
  } cond_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_EVAL  = 2'd1,
    ST_ISSUE = 2'd2,
    ST_FLUSH = 2'd3
  } state_e;

  localparam int FLAG_Z = 0;
  localparam int FLAG_C = 1;
  localparam int FLAG_S = 2;
  localparam int FLAG_O = 3;

endpackage

// File: rtl/unidade_desvio_if.sv
// Decode request, flags, PC redirect and pipeline control signals of the
// branch unit, with views for the requester (master) and the unit (slave).
interface unidade_desvio_if #(
  parameter int ADDR_WIDTH = 16
);
  logic                  br_valid;
  logic                  br_ready;
  logic [3:0]            br_cond;
  logic [ADDR_WIDTH-1:0] br_target;
  logic [ADDR_WIDTH-1:0] br_next_pc;
  logic [3:0]            ZCSO;
  logic                  pc_valid;
  logic                  pc_ready;
  logic [ADDR_WIDTH-1:0] pc_value;
  logic                  taken;
  logic                  flush;
  logic                  busy;

  modport master (
    output br_valid, br_cond, br_target, br_next_pc, ZCSO, pc_ready,
    input  br_ready, pc_valid, pc_value, taken, flush, busy
  );

  modport slave (
    input  br_valid, br_cond, br_target, br_next_pc, ZCSO, pc_ready,
    output br_ready, pc_valid, pc_value, taken, flush, busy
  );
endinterface

// File: rtl/unidade_desvio_avaliador.sv
// Combinational condition evaluator: condition code and Z/C/S/O flags in,
// branch-taken decision out.
module avaliador_condicao
  import desvio_pkg::*;
(
  input  cond_e      i_cond,
  input  logic [3:0] i_flags,
  output logic       o_taken
);

  logic w_z;
  logic w_c;
  logic w_s;
  logic w_o;

  assign w_z = i_flags[FLAG_Z];
  assign w_c = i_flags[FLAG_C];
  assign w_s = i_flags[FLAG_S];
  assign w_o = i_flags[FLAG_O];

  // Decode the condition against the flags
  always_comb begin
    o_taken = 1'b0;
    case (i_cond)
      COND_AL: o_taken = 1'b1;
      COND_NV: o_taken = 1'b0;
      COND_EQ: o_taken = w_z;
      COND_NE: o_taken = ~w_z;
      COND_CS: o_taken = w_c;
      COND_CC: o_taken = ~w_c;
      COND_MI: o_taken = w_s;
      COND_PL: o_taken = ~w_s;
      COND_VS: o_taken = w_o;
      COND_VC: o_taken = ~w_o;
      COND_LT: o_taken = w_s ^ w_o;
      COND_GE: o_taken = ~(w_s ^ w_o);
      COND_LE: o_taken = w_z | (w_s ^ w_o);
      COND_GT: o_taken = ~w_z & ~(w_s ^ w_o);
      COND_LS: o_taken = w_c | w_z;
      COND_HI: o_taken = ~w_c & ~w_z;
      default: o_taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/unidade_desvio.sv
// Branch resolution stage: captures a request, evaluates it on the flags one
// cycle later, redirects the PC on a taken branch and then flushes the pipe.
module unidade_desvio
  import desvio_pkg::*;
#(
  parameter int ADDR_WIDTH   = 16,
  parameter int FLUSH_CYCLES = 2
) (
  input logic              clock,
  input logic              reset,
  unidade_desvio_if.slave  bus
);

  localparam int CW = (FLUSH_CYCLES > 0) ? $clog2(FLUSH_CYCLES + 1) : 1;

  state_e                r_state;
  state_e                w_state_next;
  cond_e                 r_cond;
  logic [ADDR_WIDTH-1:0] r_target;
  logic [ADDR_WIDTH-1:0] r_next_pc;
  logic                  r_taken;
  logic [CW-1:0]         r_cnt;
  logic                  w_taken;
  logic                  w_dbg_unused;

  avaliador_condicao u_avaliador (
    .i_cond  (r_cond),
    .i_flags (bus.ZCSO),
    .o_taken (w_taken)
  );

  // State register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (bus.br_valid) w_state_next = ST_EVAL;
        else              w_state_next = ST_IDLE;
      end
      ST_EVAL: begin
        if (w_taken) w_state_next = ST_ISSUE;
        else         w_state_next = ST_IDLE;
      end
      ST_ISSUE: begin
        if (bus.pc_ready) begin
          if (FLUSH_CYCLES == 0) w_state_next = ST_IDLE;
          else                   w_state_next = ST_FLUSH;
        end else begin
          w_state_next = ST_ISSUE;
        end
      end
      ST_FLUSH: begin
        // <= guards against a stuck zero count, which the load never produces
        if (r_cnt <= CW'(1)) w_state_next = ST_IDLE;
        else                 w_state_next = ST_FLUSH;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Request capture, decision register and flush counter
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_cond    <= COND_AL;
      r_target  <= {ADDR_WIDTH{1'b0}};
      r_next_pc <= {ADDR_WIDTH{1'b0}};
      r_taken   <= 1'b0;
      r_cnt     <= {CW{1'b0}};
    end else begin
      if (r_state == ST_IDLE && bus.br_valid) begin
        r_cond    <= cond_e'(bus.br_cond);
        r_target  <= bus.br_target;
        r_next_pc <= bus.br_next_pc;
      end
      if (r_state == ST_EVAL) begin
        r_taken <= w_taken;
      end
      if (r_state == ST_ISSUE && bus.pc_ready) begin
        r_cnt <= CW'(FLUSH_CYCLES);
      end else if (r_state == ST_FLUSH && r_cnt != {CW{1'b0}}) begin
        r_cnt <= r_cnt - CW'(1);
      end
    end
  end

  // Fall-through PC is kept for debug visibility only
  assign w_dbg_unused = ^r_next_pc;

  assign bus.br_ready = (r_state == ST_IDLE);
  assign bus.busy     = (r_state != ST_IDLE);
  assign bus.pc_valid = (r_state == ST_ISSUE);
  assign bus.flush    = (r_state == ST_FLUSH);
  assign bus.pc_value = r_target;
  assign bus.taken    = r_taken;

endmodule
